// File: rtl/fwd_operand_mux.sv
// Registered operand forwarder for the ID/EX boundary: per-operand priority select
// (EX > MEM > [WB] > regfile) plus a saturating forward-hit counter. Optional WB source: FWD_WB_EN.

module fwd_operand_sel #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_regwrite,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_regwrite,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] val,
    output logic [1:0]        code
);
`ifndef FWD_WB_EN
    logic wb_unused;
    assign wb_unused = ^{wb_regwrite, wb_rd, wb_result};
`endif

    always_comb begin
        val  = rf_data;
        code = 2'd0;
        // XZR always reads as zero, even if a producer claims to write it
        if (src == ADDR_W'(ZERO_REG)) begin
            val = '0;
        end else if (ex_regwrite && ex_rd == src) begin
            val  = ex_result;
            code = 2'd2;
        end else if (mem_regwrite && mem_rd == src) begin
            val  = mem_result;
            code = 2'd1;
        end
`ifdef FWD_WB_EN
        else if (wb_regwrite && wb_rd == src) begin
            val  = wb_result;
            code = 2'd3;
        end
`endif
    end
endmodule

module fwd_operand_mux #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rn,
    input  logic [ADDR_W-1:0] id_rm,
    input  logic [DATA_W-1:0] id_rn_data,
    input  logic [DATA_W-1:0] id_rm_data,
    input  logic              ex_regwrite,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_regwrite,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_opa,
    output logic [DATA_W-1:0] ex_opb,
    output logic [1:0]        ex_sel_a,
    output logic [1:0]        ex_sel_b,
    output logic [CNT_W-1:0]  fwd_hit_cnt
);
    // lane 0 = Rn (operand A), lane 1 = Rm (operand B)
    logic [1:0][ADDR_W-1:0] src;
    logic [1:0][DATA_W-1:0] rf_data;
    logic [1:0][DATA_W-1:0] val;
    logic [1:0][1:0]        code;

    assign src     = {id_rm, id_rn};
    assign rf_data = {id_rm_data, id_rn_data};

    for (genvar i = 0; i < 2; i++) begin : g_op
        fwd_operand_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sel (
            .src(src[i]), .rf_data(rf_data[i]),
            .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_result(ex_result),
            .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
            .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
            .val(val[i]), .code(code[i])
        );
    end

    logic             cap;
    logic [1:0]       hits;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    assign cap      = id_valid & ~stall & ~flush;
    assign hits     = {1'b0, code[0] != 2'd0} + {1'b0, code[1] != 2'd0};
    // one extra bit catches overflow so a +2 from max-1 clamps instead of wrapping
    assign cnt_sum  = {1'b0, fwd_hit_cnt} + {{(CNT_W-1){1'b0}}, hits};
    assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_opa      <= '0;
            ex_opb      <= '0;
            ex_sel_a    <= 2'd0;
            ex_sel_b    <= 2'd0;
            fwd_hit_cnt <= '0;
        end else begin
            ex_valid <= cap;
            if (cap) begin
                ex_opa   <= val[0];
                ex_opb   <= val[1];
                ex_sel_a <= code[0];
                ex_sel_b <= code[1];
            end else begin
                ex_sel_a <= 2'd0;
                ex_sel_b <= 2'd0;
            end
            if (cnt_clr)
                fwd_hit_cnt <= '0;
            else if (cap)
                fwd_hit_cnt <= cnt_next;
        end
    end
endmodule

// File: tb/tb_fwd_operand_mux.sv
// Directed bench for fwd_operand_mux (CNT_W=4 so saturation is reachable quickly).

module tb_fwd_operand_mux;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rn, id_rm;
    logic [DATA_W-1:0] id_rn_data, id_rm_data;
    logic              ex_regwrite, mem_regwrite, wb_regwrite;
    logic [ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
    logic [DATA_W-1:0] ex_result, mem_result, wb_result;
    logic              stall, flush, cnt_clr;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_opa, ex_opb;
    logic [1:0]        ex_sel_a, ex_sel_b;
    logic [CNT_W-1:0]  fwd_hit_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    fwd_operand_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rn_data(id_rn_data), .id_rm_data(id_rm_data),
        .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .ex_valid(ex_valid), .ex_opa(ex_opa), .ex_opb(ex_opb),
        .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .fwd_hit_cnt(fwd_hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rn = 5'd1; id_rm = 5'd2;
        id_rn_data = 64'h0; id_rm_data = 64'h0;
        ex_regwrite = 1'b0; ex_rd = 5'd0; ex_result = 64'h0;
        mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = 64'h0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_result = 64'h0;
        stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    endtask

    // both operands hit the EX producer: +2 per capture
    task automatic fwd2();
        idle();
        id_valid = 1'b1; id_rn = 5'd9; id_rm = 5'd9;
        ex_regwrite = 1'b1; ex_rd = 5'd9; ex_result = 64'h99;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        chk("rst_valid", ex_valid, 0);
        chk("rst_opa", ex_opa, 0);
        chk("rst_opb", ex_opb, 0);
        chk("rst_sel", {ex_sel_a, ex_sel_b}, 0);
        chk("rst_cnt", fwd_hit_cnt, 0);
        @(negedge clk); reset = 1'b0;

        // priority: EX beats MEM/WB
        id_valid = 1'b1; id_rn = 5'd5; id_rm = 5'd5;
        id_rn_data = 64'h1; id_rm_data = 64'h2;
        ex_regwrite = 1'b1; ex_rd = 5'd5; ex_result = 64'hAAAA;
        mem_regwrite = 1'b1; mem_rd = 5'd5; mem_result = 64'hBBBB;
        wb_regwrite = 1'b1; wb_rd = 5'd5; wb_result = 64'hCCCC;
        cyc();
        chk("pri_ex_valid", ex_valid, 1);
        chk("pri_ex_opa", ex_opa, 64'hAAAA);
        chk("pri_ex_opb", ex_opb, 64'hAAAA);
        chk("pri_ex_sel", {ex_sel_a, ex_sel_b}, 4'b1010);
        chk("pri_ex_cnt", fwd_hit_cnt, 2);

        // MEM beats WB
        ex_regwrite = 1'b0;
        cyc();
        chk("pri_mem_opa", ex_opa, 64'hBBBB);
        chk("pri_mem_opb", ex_opb, 64'hBBBB);
        chk("pri_mem_sel", {ex_sel_a, ex_sel_b}, 4'b0101);
        chk("pri_mem_cnt", fwd_hit_cnt, 4);

        // zero register ignores producers and regfile data
        idle();
        id_valid = 1'b1; id_rn = 5'd31; id_rn_data = 64'h1234;
        id_rm = 5'd3; id_rm_data = 64'h33;
        ex_regwrite = 1'b1; ex_rd = 5'd31; ex_result = 64'hDEAD;
        cyc();
        chk("xzr_opa", ex_opa, 0);
        chk("xzr_sel_a", ex_sel_a, 0);
        chk("xzr_opb", ex_opb, 64'h33);
        chk("xzr_cnt", fwd_hit_cnt, 4);

        // bubbles hold operands and clear selects
        idle();
        id_valid = 1'b1; id_rn = 5'd2; id_rn_data = 64'h11; id_rm = 5'd3; id_rm_data = 64'h22;
        cyc();
        chk("cap_opa", ex_opa, 64'h11);
        chk("cap_valid", ex_valid, 1);
        id_rn = 5'd5; ex_regwrite = 1'b1; ex_rd = 5'd5; ex_result = 64'h55;
        stall = 1'b1;
        cyc();
        chk("stall_valid", ex_valid, 0);
        chk("stall_sel_a", ex_sel_a, 0);
        chk("stall_opa", ex_opa, 64'h11);
        chk("stall_cnt", fwd_hit_cnt, 4);
        stall = 1'b0; flush = 1'b1;
        cyc();
        chk("flush_valid", ex_valid, 0);
        chk("flush_sel_a", ex_sel_a, 0);
        chk("flush_opa", ex_opa, 64'h11);
        chk("flush_cnt", fwd_hit_cnt, 4);
        stall = 1'b1;
        cyc();
        chk("sf_valid", ex_valid, 0);
        chk("sf_opa", ex_opa, 64'h11);

        // async reset mid-stream, no clock edge needed
        stall = 1'b0; flush = 1'b0;
        cyc();
        chk("pre_rst_valid", ex_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_opa", ex_opa, 0);
        chk("arst_sel", {ex_sel_a, ex_sel_b}, 0);
        chk("arst_cnt", fwd_hit_cnt, 0);
        @(negedge clk); reset = 1'b0;
        idle();
        id_valid = 1'b1; id_rn = 5'd2; id_rn_data = 64'h42;
        cyc();
        chk("first_valid", ex_valid, 1);
        chk("first_opa", ex_opa, 64'h42);
        chk("first_cnt", fwd_hit_cnt, 0);

        // saturation at 15
        fwd2();
        for (int i = 0; i < 7; i++) cyc();
        chk("sat_pre14", fwd_hit_cnt, 14);
        cyc();
        chk("sat_15", fwd_hit_cnt, 15);
        cyc();
        chk("sat_hold2", fwd_hit_cnt, 15);
        id_rm = 5'd4;
        cyc();
        chk("sat_hold1", fwd_hit_cnt, 15);
        fwd2(); cnt_clr = 1'b1;
        cyc();
        chk("clr_over_fwd", fwd_hit_cnt, 0);
        chk("clr_opa", ex_opa, 64'h99);
        cnt_clr = 1'b0; id_rm = 5'd4;
        cyc();
        chk("clr_then_1", fwd_hit_cnt, 1);

        // WB-only producer
        idle();
        id_valid = 1'b1; id_rn = 5'd7; id_rn_data = 64'h70;
        wb_regwrite = 1'b1; wb_rd = 5'd7; wb_result = 64'h77;
        cyc();
`ifdef FWD_WB_EN
        chk("wb_opa", ex_opa, 64'h77);
        chk("wb_sel_a", ex_sel_a, 3);
        chk("wb_cnt", fwd_hit_cnt, 2);
`else
        chk("wb_opa", ex_opa, 64'h70);
        chk("wb_sel_a", ex_sel_a, 0);
        chk("wb_cnt", fwd_hit_cnt, 1);
`endif

        idle();
        cyc();
        chk("idle_valid", ex_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
